// File: rtl/ptmch_pkg.sv
// Shared types and constants for the ptmch SPI NAND command monitor.
// Opcodes, command/state enums, address lengths and the saturating increment.
`timescale 1ns/1ps
package ptmch_pkg;

  localparam logic [7:0] OPC_PRGEXCT = 8'h10;
  localparam logic [7:0] OPC_RDSTAT0 = 8'h0F;
  localparam logic [7:0] OPC_RDSTAT1 = 8'h05;
  localparam logic [7:0] OPC_BLKERS  = 8'hD8;
  localparam logic [7:0] OPC_PDREAD  = 8'h13;

  localparam int ADDR_LEN_SHORT = 8;
  localparam int ADDR_LEN_LONG  = 24;

  typedef enum logic [1:0] {
    CMD_PRGEXCT,
    CMD_RDSTAT,
    CMD_BLKERS,
    CMD_PDREAD
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    ADDR,
    ARMED,
    SKIP
  } mon_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ptmch_spi_sync.sv
// Synchronizes the snooped SPI pins into CLK100M and detects SCLK rise and CS_N edges.
// Edges are suppressed until the chain has refilled after reset, so a pin level at release is never taken as an edge.
`timescale 1ns/1ps
module ptmch_spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] cs_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES:0]   prime_sr;
  logic                   sclk_d;
  logic                   cs_d;
  logic                   primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr  <= '0;
      cs_sr    <= '1;
      mosi_sr  <= '0;
      sclk_d   <= 1'b0;
      cs_d     <= 1'b1;
      prime_sr <= '0;
    end else begin
      sclk_sr  <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sclk_d   <= sclk_sr[SYNC_STAGES-1];
      cs_d     <= cs_sr[SYNC_STAGES-1];
      prime_sr <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign primed    = prime_sr[SYNC_STAGES];
  assign sclk_rise = primed &  sclk_sr[SYNC_STAGES-1] & ~sclk_d;
  assign cs_fall   = primed & ~cs_sr[SYNC_STAGES-1]   &  cs_d;
  assign cs_rise   = primed &  cs_sr[SYNC_STAGES-1]   & ~cs_d;
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/ptmch_cmd_monitor.sv
// Decodes snooped SPI NAND commands, captures their address and counts those
// that land inside each command's programmed window.
`timescale 1ns/1ps
module ptmch_cmd_monitor
  import ptmch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK100M,
  input  logic        RESET_N,
  input  logic        SPI_SCLK,
  input  logic        SPI_CS_N,
  input  logic        SPI_MOSI,
  input  logic        CNT_CLR,
  input  logic [23:0] PRGEXCT_LOW_ADDR,
  input  logic [23:0] PRGEXCT_HIGH_ADDR,
  input  logic [23:0] RDSTAT_LOW_ADDR,
  input  logic [23:0] RDSTAT_HIGH_ADDR,
  input  logic [23:0] BLKERS_LOW_ADDR,
  input  logic [23:0] BLKERS_HIGH_ADDR,
  input  logic [23:0] PDREAD_LOW_ADDR,
  input  logic [23:0] PDREAD_HIGH_ADDR,
  output logic [31:0] PRGEXCT,
  output logic [31:0] RDSTAT,
  output logic [31:0] BLKERS,
  output logic [31:0] PDREAD,
  output logic [3:0]  TRG_PLS,
  output logic [2:0]  dbg_state
);

  logic sclk_rise, cs_fall, cs_rise, mosi_s;

  ptmch_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (CLK100M),
    .rst_n     (RESET_N),
    .spi_sclk  (SPI_SCLK),
    .spi_cs_n  (SPI_CS_N),
    .spi_mosi  (SPI_MOSI),
    .sclk_rise (sclk_rise),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  mon_state_e  state_q, state_d;
  logic [4:0]  bit_cnt_q;
  logic [23:0] shreg_q;
  cmd_e        cmd_q;

  logic [7:0]  opcode_nxt;
  logic        opc_valid;
  cmd_e        opc_cmd;
  logic [4:0]  last_bit;

  assign opcode_nxt = {shreg_q[6:0], mosi_s};
  assign last_bit   = (cmd_q == CMD_RDSTAT) ? 5'(ADDR_LEN_SHORT - 1) : 5'(ADDR_LEN_LONG - 1);
  assign dbg_state  = state_q;

  always_comb begin
    opc_valid = 1'b1;
    opc_cmd   = CMD_PRGEXCT;
    case (opcode_nxt)
      OPC_PRGEXCT:              opc_cmd = CMD_PRGEXCT;
      OPC_RDSTAT0, OPC_RDSTAT1: opc_cmd = CMD_RDSTAT;
      OPC_BLKERS:               opc_cmd = CMD_BLKERS;
      OPC_PDREAD:               opc_cmd = CMD_PDREAD;
      default:                  opc_valid = 1'b0;
    endcase
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // CS_N edges take priority over SCLK: a rise always ends the command.
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else if (cs_fall) begin
      state_d = OPC;
    end else if (sclk_rise) begin
      case (state_q)
        OPC:     if (bit_cnt_q == 5'd7) state_d = opc_valid ? ADDR : SKIP;
        ADDR:    if (bit_cnt_q == last_bit) state_d = ARMED;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      cmd_q     <= CMD_PRGEXCT;
    end else if (cs_rise || cs_fall) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else if (sclk_rise && (state_q == OPC || state_q == ADDR)) begin
      shreg_q <= {shreg_q[22:0], mosi_s};
      if (state_q == OPC && bit_cnt_q == 5'd7) begin
        bit_cnt_q <= '0;
        cmd_q     <= opc_cmd;
      end else begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
      end
    end
  end

  // Commit: compare the captured address with the live window of this command.
  logic        commit, hit;
  logic [23:0] cmd_addr, win_low, win_high;
  logic [3:0]  hit_vec;

  assign commit   = cs_rise && (state_q == ARMED);
  assign cmd_addr = (cmd_q == CMD_RDSTAT) ? {16'h0, shreg_q[7:0]} : shreg_q;

  always_comb begin
    win_low  = PRGEXCT_LOW_ADDR;
    win_high = PRGEXCT_HIGH_ADDR;
    case (cmd_q)
      CMD_RDSTAT: begin win_low = RDSTAT_LOW_ADDR; win_high = RDSTAT_HIGH_ADDR; end
      CMD_BLKERS: begin win_low = BLKERS_LOW_ADDR; win_high = BLKERS_HIGH_ADDR; end
      CMD_PDREAD: begin win_low = PDREAD_LOW_ADDR; win_high = PDREAD_HIGH_ADDR; end
      default:    begin win_low = PRGEXCT_LOW_ADDR; win_high = PRGEXCT_HIGH_ADDR; end
    endcase
  end

  assign hit     = commit && (win_low <= cmd_addr) && (cmd_addr <= win_high);
  assign hit_vec = hit ? (4'(1) << cmd_q) : 4'b0000;

  logic [31:0] prgexct_q, rdstat_q, blkers_q, pdread_q;

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N)        prgexct_q <= '0;
    else if (CNT_CLR)    prgexct_q <= '0;
    else if (hit_vec[0]) prgexct_q <= sat_inc(prgexct_q);
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N)        rdstat_q <= '0;
    else if (CNT_CLR)    rdstat_q <= '0;
    else if (hit_vec[1]) rdstat_q <= sat_inc(rdstat_q);
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N)        blkers_q <= '0;
    else if (CNT_CLR)    blkers_q <= '0;
    else if (hit_vec[2]) blkers_q <= sat_inc(blkers_q);
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N)        pdread_q <= '0;
    else if (CNT_CLR)    pdread_q <= '0;
    else if (hit_vec[3]) pdread_q <= sat_inc(pdread_q);
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) TRG_PLS <= '0;
    else          TRG_PLS <= hit_vec;
  end

  assign PRGEXCT = prgexct_q;
  assign RDSTAT  = rdstat_q;
  assign BLKERS  = blkers_q;
  assign PDREAD  = pdread_q;

endmodule

// File: tb/tb_ptmch_cmd_monitor.sv
// Directed bench for ptmch_cmd_monitor: drives SPI commands bit by bit and
// checks counters and trigger pulses against hand-computed values.
`timescale 1ns/1ps
module tb_ptmch_cmd_monitor;

  logic        CLK100M, RESET_N;
  logic        SPI_SCLK, SPI_CS_N, SPI_MOSI, CNT_CLR;
  logic [23:0] PRGEXCT_LOW_ADDR, PRGEXCT_HIGH_ADDR, RDSTAT_LOW_ADDR, RDSTAT_HIGH_ADDR;
  logic [23:0] BLKERS_LOW_ADDR, BLKERS_HIGH_ADDR, PDREAD_LOW_ADDR, PDREAD_HIGH_ADDR;
  logic [31:0] PRGEXCT, RDSTAT, BLKERS, PDREAD;
  logic [3:0]  TRG_PLS;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int pls_cnt[4];

  ptmch_cmd_monitor #(.SYNC_STAGES(2)) dut (
    .CLK100M(CLK100M), .RESET_N(RESET_N),
    .SPI_SCLK(SPI_SCLK), .SPI_CS_N(SPI_CS_N), .SPI_MOSI(SPI_MOSI), .CNT_CLR(CNT_CLR),
    .PRGEXCT_LOW_ADDR(PRGEXCT_LOW_ADDR), .PRGEXCT_HIGH_ADDR(PRGEXCT_HIGH_ADDR),
    .RDSTAT_LOW_ADDR(RDSTAT_LOW_ADDR), .RDSTAT_HIGH_ADDR(RDSTAT_HIGH_ADDR),
    .BLKERS_LOW_ADDR(BLKERS_LOW_ADDR), .BLKERS_HIGH_ADDR(BLKERS_HIGH_ADDR),
    .PDREAD_LOW_ADDR(PDREAD_LOW_ADDR), .PDREAD_HIGH_ADDR(PDREAD_HIGH_ADDR),
    .PRGEXCT(PRGEXCT), .RDSTAT(RDSTAT), .BLKERS(BLKERS), .PDREAD(PDREAD),
    .TRG_PLS(TRG_PLS), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial CLK100M = 1'b0;
  always #5 CLK100M = ~CLK100M;

  // Cycles with each trigger bit high, sampled away from the active edge
  always @(negedge CLK100M) begin
    for (int i = 0; i < 4; i++) if (TRG_PLS[i] === 1'b1) pls_cnt[i]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic shift_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      SPI_MOSI = data[i];
      #40 SPI_SCLK = 1'b1;
      #40 SPI_SCLK = 1'b0;
    end
  endtask

  task automatic spi_cmd(input logic [31:0] data, input int nbits, input int gap_ns);
    SPI_CS_N = 1'b0;
    #40;
    shift_bits(data, nbits);
    #40 SPI_CS_N = 1'b1;
    #(gap_ns);
  endtask

  task automatic check_counts(input string name, input logic [31:0] p, input logic [31:0] r,
                              input logic [31:0] b, input logic [31:0] d);
    @(negedge CLK100M);
    checks++; if (PRGEXCT !== p) begin errors++; $display("FAIL %s.prgexct: got %h want %h", name, PRGEXCT, p); end
    checks++; if (RDSTAT  !== r) begin errors++; $display("FAIL %s.rdstat: got %h want %h", name, RDSTAT, r); end
    checks++; if (BLKERS  !== b) begin errors++; $display("FAIL %s.blkers: got %h want %h", name, BLKERS, b); end
    checks++; if (PDREAD  !== d) begin errors++; $display("FAIL %s.pdread: got %h want %h", name, PDREAD, d); end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; SPI_SCLK = 1'b0; SPI_CS_N = 1'b1; SPI_MOSI = 1'b0; CNT_CLR = 1'b0;
    PRGEXCT_LOW_ADDR = 24'h0; PRGEXCT_HIGH_ADDR = 24'hFFFFFF;
    RDSTAT_LOW_ADDR  = 24'h0; RDSTAT_HIGH_ADDR  = 24'hFFFFFF;
    BLKERS_LOW_ADDR  = 24'h0; BLKERS_HIGH_ADDR  = 24'hFFFFFF;
    PDREAD_LOW_ADDR  = 24'h0; PDREAD_HIGH_ADDR  = 24'hFFFFFF;
    #33 RESET_N = 1'b1;
    #100;
    check_counts("reset", 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (TRG_PLS !== 4'b0) begin errors++; $display("FAIL reset.trg_pls: got %b want 0000", TRG_PLS); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset.state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_prgexct_hit;
    int base0, base1;
    base0 = pls_cnt[0]; base1 = pls_cnt[1] + pls_cnt[2] + pls_cnt[3];
    spi_cmd(32'h10000123, 32, 120);
    check_counts("prg_hit", 32'd1, 32'd0, 32'd0, 32'd0);
    checks++; if (pls_cnt[0] - base0 !== 1) begin errors++; $display("FAIL prg_hit.pulse_cycles: got %0d want 1", pls_cnt[0] - base0); end
    checks++; if (pls_cnt[1] + pls_cnt[2] + pls_cnt[3] - base1 !== 0) begin errors++; $display("FAIL prg_hit.other_pulses: got %0d want 0", pls_cnt[1] + pls_cnt[2] + pls_cnt[3] - base1); end
  endtask

  task automatic test_window;
    int base2;
    BLKERS_LOW_ADDR = 24'h000100; BLKERS_HIGH_ADDR = 24'h0001FF;
    base2 = pls_cnt[2];
    spi_cmd(32'hD8000200, 32, 120);
    check_counts("blk_above", 32'd1, 32'd0, 32'd0, 32'd0);
    checks++; if (pls_cnt[2] != base2) begin errors++; $display("FAIL blk_above.pulse: got %0d want 0", pls_cnt[2] - base2); end
    spi_cmd(32'hD80001FF, 32, 120);
    check_counts("blk_high_edge", 32'd1, 32'd0, 32'd1, 32'd0);
    spi_cmd(32'hD8000100, 32, 120);
    check_counts("blk_low_edge", 32'd1, 32'd0, 32'd2, 32'd0);
    spi_cmd(32'hD80000FF, 32, 120);
    check_counts("blk_below", 32'd1, 32'd0, 32'd2, 32'd0);
    BLKERS_LOW_ADDR = 24'h000200; BLKERS_HIGH_ADDR = 24'h000100;
    spi_cmd(32'hD8000150, 32, 120);
    check_counts("blk_empty", 32'd1, 32'd0, 32'd2, 32'd0);
    BLKERS_LOW_ADDR = 24'h0; BLKERS_HIGH_ADDR = 24'hFFFFFF;
  endtask

  task automatic test_rdstat;
    RDSTAT_LOW_ADDR = 24'h0000C0; RDSTAT_HIGH_ADDR = 24'h0000C0;
    spi_cmd(32'h00000FC0, 16, 120);
    spi_cmd(32'h000005C0, 16, 120);
    check_counts("rd_both", 32'd1, 32'd2, 32'd2, 32'd0);
    spi_cmd(32'h00000FA0, 16, 120);
    check_counts("rd_miss", 32'd1, 32'd2, 32'd2, 32'd0);
    spi_cmd(32'h0005C0FF, 24, 120);
    check_counts("rd_trailing", 32'd1, 32'd3, 32'd2, 32'd0);
  endtask

  task automatic test_abort;
    int base3;
    base3 = pls_cnt[3];
    spi_cmd(32'h01300010, 28, 120);
    check_counts("pd_abort", 32'd1, 32'd3, 32'd2, 32'd0);
    checks++; if (pls_cnt[3] != base3) begin errors++; $display("FAIL pd_abort.pulse: got %0d want 0", pls_cnt[3] - base3); end
    spi_cmd(32'h03000000, 32, 120);
    check_counts("unknown_opc", 32'd1, 32'd3, 32'd2, 32'd0);
  endtask

  task automatic test_back_to_back;
    spi_cmd(32'h10000001, 32, 40);
    spi_cmd(32'h10000002, 32, 120);
    check_counts("b2b", 32'd3, 32'd3, 32'd2, 32'd0);
  endtask

  task automatic test_saturation;
    @(negedge CLK100M);
    force dut.pdread_q = 32'hFFFF_FFFE;
    #1 release dut.pdread_q;
    spi_cmd(32'h13000001, 32, 120);
    check_counts("sat_first", 32'd3, 32'd3, 32'd2, 32'hFFFF_FFFF);
    spi_cmd(32'h13000001, 32, 120);
    check_counts("sat_hold", 32'd3, 32'd3, 32'd2, 32'hFFFF_FFFF);
  endtask

  task automatic test_clear_collision;
    SPI_CS_N = 1'b0;
    #40;
    shift_bits(32'h13000001, 32);
    #40;
    @(negedge CLK100M);
    SPI_CS_N = 1'b1;
    @(posedge CLK100M);
    @(posedge CLK100M);
    #1 CNT_CLR = 1'b1;
    @(posedge CLK100M);
    #1 CNT_CLR = 1'b0;
    #100;
    check_counts("clr_collide", 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_mid_cmd;
    int base0;
    spi_cmd(32'h10000005, 32, 120);
    check_counts("pre_rst", 32'd1, 32'd0, 32'd0, 32'd0);
    SPI_CS_N = 1'b0;
    #40;
    shift_bits(32'h00001000, 16);
    RESET_N = 1'b0;
    #25;
    checks++; if (PRGEXCT !== 32'd0) begin errors++; $display("FAIL rst_async.prgexct: got %h want 0", PRGEXCT); end
    checks++; if (TRG_PLS !== 4'b0) begin errors++; $display("FAIL rst_async.trg_pls: got %b want 0000", TRG_PLS); end
    RESET_N = 1'b1;
    #40;
    shift_bits(32'h00000005, 16);
    #40 SPI_CS_N = 1'b1;
    #120;
    check_counts("rst_inflight", 32'd0, 32'd0, 32'd0, 32'd0);
    base0 = pls_cnt[0];
    spi_cmd(32'h10000005, 32, 120);
    check_counts("post_rst", 32'd1, 32'd0, 32'd0, 32'd0);
    checks++; if (pls_cnt[0] - base0 !== 1) begin errors++; $display("FAIL post_rst.pulse_cycles: got %0d want 1", pls_cnt[0] - base0); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) pls_cnt[i] = 0;
    test_reset;
    test_prgexct_hit;
    test_window;
    test_rdstat;
    test_abort;
    test_back_to_back;
    test_saturation;
    test_clear_collision;
    test_reset_mid_cmd;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ptmch_cmd_monitor.md
# ptmch_cmd_monitor

Snoops the SPI NAND bus between host and flash, decodes the four tracked commands (Program Execute, Read Status, 128 KB Block Erase, Page Data Read) and extracts each command's address. Each command whose address falls inside its programmed low/high window increments that command's 32-bit counter. It sits between the board SPI pins and the ptmch register block, consuming the eight window registers and producing the four counter values that the register block returns on Avalon reads.

## Interface
- SYNC_STAGES, 2, synchronizer depth for SPI inputs (≥2)
- CLK100M  in  1  system clock, 100 MHz
- RESET_N  in  1  asynchronous, active-low reset
- SPI_SCLK  in  1  snooped SPI clock, asynchronous, mode 0, ≤25 MHz
- SPI_CS_N  in  1  snooped chip select, asynchronous, active-low
- SPI_MOSI  in  1  snooped host-to-flash data, asynchronous
- CNT_CLR  in  1  one-cycle pulse, clears all four counters
- PRGEXCT_LOW_ADDR / PRGEXCT_HIGH_ADDR  in  24 each  Program Execute window
- RDSTAT_LOW_ADDR / RDSTAT_HIGH_ADDR  in  24 each  Read Status window
- BLKERS_LOW_ADDR / BLKERS_HIGH_ADDR  in  24 each  Block Erase window
- PDREAD_LOW_ADDR / PDREAD_HIGH_ADDR  in  24 each  Page Data Read window
- PRGEXCT, RDSTAT, BLKERS, PDREAD  out  32 each  match counters
- TRG_PLS  out  4  one-cycle pulse per counted command: [0] PRGEXCT, [1] RDSTAT, [2] BLKERS, [3] PDREAD

## Operation
- SCLK, CS_N and MOSI pass through a SYNC_STAGES flop chain. SCLK rising and CS_N falling/rising edges are detected on the synchronized copies. MOSI is sampled on each detected SCLK rise, MSB first.
- FSM states:
  - IDLE: entered on CS_N high; the bit counter is cleared.
  - OPC: entered on CS_N fall. After 8 bits, go to ADDR if the opcode is 0x10 (PRGEXCT), 0x0F or 0x05 (RDSTAT), 0xD8 (BLKERS) or 0x13 (PDREAD); otherwise go to SKIP.
  - ADDR: shifts address bits. RDSTAT needs 8 bits; the others need 24 bits (8 dummy + 16 page). On reaching the count, go to ARMED.
  - ARMED: further bits are ignored.
  - SKIP: waits for CS_N high.
- Address formation:
  - RDSTAT: address = {16'h0, feature byte}.
  - Others: address = the 24 captured bits.
- Commit: on CS_N rise while in ARMED, compare LOW ≤ addr ≤ HIGH (unsigned, 24-bit) against that command's window. On a match, increment the counter and pulse the TRG_PLS bit. The FSM returns to IDLE.
- CS_N rise in OPC, ADDR or SKIP aborts the command: no count, no pulse, FSM to IDLE.
- LOW > HIGH means the window is empty and nothing matches. Reset windows 0..FFFFFF match every address.
- Window inputs are sampled at the commit cycle only; changes mid-command take effect only for that commit.
- Counters saturate at 32'hFFFF_FFFF.
- CNT_CLR zeroes all counters. If a clear and an increment coincide, the clear wins and the count result is 0.
- Reset, including mid-command: FSM to IDLE, shift register and bit count cleared, all counters 0, TRG_PLS 0. A command in flight when reset releases is not counted; the FSM waits for the next CS_N fall.

## Timing
- Synchronizer plus edge detect: an SPI event is acted on SYNC_STAGES+1 CLK100M cycles after it arrives at the pin.
- Commit: the counter and TRG_PLS update one cycle after the CS_N-rise edge is detected. TRG_PLS is high for exactly one cycle.
- Minimum SCLK high or low time is 2 CLK100M periods; SCLK ≤25 MHz is guaranteed correct.
- Minimum CS_N high time between commands is 3 CLK100M periods.
- Counter outputs are registered and change only on commit or clear.

## Structure
- Package ptmch_pkg holds:
  - opcode constants: OPC_PRGEXCT = 8'h10, OPC_RDSTAT0 = 8'h0F, OPC_RDSTAT1 = 8'h05, OPC_BLKERS = 8'hD8, OPC_PDREAD = 8'h13
  - cmd_e enum {CMD_PRGEXCT, CMD_RDSTAT, CMD_BLKERS, CMD_PDREAD}
  - mon_state_e enum {IDLE, OPC, ADDR, ARMED, SKIP}
  - address-length constants: 8 and 24
- Sub-module ptmch_spi_sync, parameterized by SYNC_STAGES: synchronizes the three SPI inputs and outputs sclk_rise, cs_fall, cs_rise and mosi_s.
- Top level contains the FSM, shift register, comparators and four saturating counters.

## Test plan
- Program Execute hit: CS_N low, send 10 00 01 23, CS_N high, windows at reset -> PRGEXCT = 1, TRG_PLS[0] pulses once, other counters 0.
- Window miss: set BLKERS window 0x000100..0x0001FF, send D8 00 02 00 -> BLKERS stays 0. Send D8 00 01 FF -> BLKERS = 1.
- Read Status with both opcodes: send 0F C0, then 05 C0, RDSTAT window 0xC0..0xC0 -> RDSTAT = 2. Then send 0F A0 -> RDSTAT stays 2.
- Abort and unknown opcode: send 13 00 01 with CS_N rising after 20 address bits -> PDREAD = 0. Send 03 00 00 00 -> no counter changes.
- Clear collision and saturation: preload PDREAD to FFFF_FFFE via repeated hits or force, then send two PDREAD hits -> value FFFF_FFFF, held. Assert CNT_CLR in the same cycle as a commit -> all counters 0.
- Reset mid-command: assert RESET_N low during the address bytes of a 10 command, then release -> all outputs 0, and the next complete 10 00 00 05 -> PRGEXCT = 1.
